piso: RTL and testbench

Parallel-in, serial-out shift register. Captures a WIDTH-bit parallel word on a synchronous load and then emits it one bit per clock on a single serial output, LSB first. It serialises small parallel words onto a one-wire data path.

---
 rtl/piso.sv | 54 +++++
 tb/tb_piso.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/piso.sv
// -----------------------------------------------------------------------------
// piso -- parallel-in, serial-out shift register
//
// Captures a WIDTH-bit parallel word on a synchronous load and then emits it
// one bit per clock on a single serial line, LSB first. Zeros are shifted in
// at the MSB, so once a word has been fully emitted the output rests at 0
// until the next load. There is no busy/done flag; the user counts WIDTH
// cycles externally.
//
// Parameters
//   WIDTH  width of the parallel word and the shift register (>= 2)
//
// Ports
//   D     in   WIDTH  parallel data word, sampled only on a load edge
//   clk   in   1      clock, rising edge active
//   clr   in   1      asynchronous reset, active low
//   load  in   1      synchronous load enable, active high (beats shifting)
//   Q     out  1      serial data out, taken directly from sreg[0]
// -----------------------------------------------------------------------------
module piso #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] D,
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  output logic             Q
);

  // A one-bit register cannot serialise anything; reject it at elaboration.
  if (WIDTH < 2) begin : g_width_check
    $error("piso: WIDTH must be 2 or more");
  end

  logic [WIDTH-1:0] sreg;

  // NOTE: state is written with non-blocking assignments so every flop
  // samples the pre-edge value of its neighbour; blocking assignments here
  // would let a bit ripple through several stages in a single edge.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      sreg <= '0;
    end else if (load) begin
      // A load discards whatever was left of the previous word.
      sreg <= D;
    end else begin
      // Logical right shift: zero fill at the MSB, no recirculation.
      sreg <= {1'b0, sreg[WIDTH-1:1]};
    end
  end

  assign Q = sreg[0];

endmodule

// File: tb/tb_piso.sv
// -----------------------------------------------------------------------------
// tb_piso -- self-checking bench for piso
//
// Two instances share clk and clr: a default WIDTH=4 unit and a WIDTH=8 unit.
// Each has a reference model built from a queue of the bits still to be sent:
// a load refills the queue with D[0..WIDTH-1], a shift drops the front, and a
// reset empties it. The expected serial output is the front of the queue, or
// 0 once it is empty. A compare process checks both outputs against their
// models every cycle; the directed sequence also checks hand-computed values.
// -----------------------------------------------------------------------------
module tb_piso;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic [3:0] d4 = '0;
  logic       load4 = 1'b0;
  logic [7:0] d8 = '0;
  logic       load8 = 1'b0;
  logic       q4;
  logic       q8;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  piso #(.WIDTH(4)) u_piso4 (
    .D    (d4),
    .clk  (clk),
    .clr  (clr),
    .load (load4),
    .Q    (q4)
  );

  piso #(.WIDTH(8)) u_piso8 (
    .D    (d8),
    .clk  (clk),
    .clr  (clr),
    .load (load8),
    .Q    (q8)
  );

  // ---------------------------------------------------------------------------
  // Reference models: queues of bits still waiting to appear on Q.
  // ---------------------------------------------------------------------------
  logic m4[$];
  logic m8[$];

  always @(posedge clk or negedge clr) begin
    if (!clr) begin
      m4.delete();
    end else if (load4) begin
      m4.delete();
      for (int i = 0; i < 4; i++) m4.push_back(d4[i]);
    end else if (m4.size() > 0) begin
      void'(m4.pop_front());
    end
  end

  always @(posedge clk or negedge clr) begin
    if (!clr) begin
      m8.delete();
    end else if (load8) begin
      m8.delete();
      for (int i = 0; i < 8; i++) m8.push_back(d8[i]);
    end else if (m8.size() > 0) begin
      void'(m8.pop_front());
    end
  end

  function automatic logic exp4();
    return (m4.size() > 0) ? m4[0] : 1'b0;
  endfunction

  function automatic logic exp8();
    return (m8.size() > 0) ? m8[0] : 1'b0;
  endfunction

  task automatic check(input string name, input logic actual, input logic expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b, expected %b", name, $time, actual, expected);
    end
  endtask

  // Per-cycle comparison against the models, 2 time units after each edge.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      check("model_q4", q4, exp4());
      check("model_q8", q8, exp8());
    end
  end

  // Advance one edge and land 3 units after it, away from the edge and after
  // the model compare; the caller then checks and drives the next inputs.
  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence with literal expectations
  // ---------------------------------------------------------------------------
  initial begin
    logic [3:0] exp_seq4;
    logic [8:0] exp_seq8;

    // Reset asserted before the first clock edge: cleared asynchronously.
    #1 clr = 1'b0;
    #1;
    check("reset_async_q4", q4, 1'b0);
    check("reset_async_q8", q8, 1'b0);

    // Reset held while D and load toggle randomly.
    for (int i = 0; i < 3; i++) begin
      d4    = 4'($urandom);
      load4 = 1'($urandom_range(0, 1));
      d8    = 8'($urandom);
      load8 = 1'($urandom_range(0, 1));
      tick();
      check("reset_hold_q4", q4, 1'b0);
      check("reset_hold_q8", q8, 1'b0);
    end
    load8 = 1'b0;

    // Load 1010 and shift 5 edges: Q = 0 | 1,0,1,0,0.
    clr = 1'b1; load4 = 1'b1; d4 = 4'b1010;
    tick();
    check("load_1010", q4, 1'b0);
    load4 = 1'b0; d4 = 4'b1111;  // D is a don't-care while shifting
    exp_seq4 = 4'b0101;          // bit i = Q after shift i+1
    for (int i = 0; i < 4; i++) begin
      tick();
      check("shift_1010", q4, exp_seq4[i]);
    end
    tick();
    check("zero_fill", q4, 1'b0);

    // Reset mid-shift: load 1010, shift once (Q=1), pulse clr for half a cycle.
    load4 = 1'b1; d4 = 4'b1010;
    tick();
    check("mid_load", q4, 1'b0);
    load4 = 1'b0;
    tick();
    check("mid_shift1", q4, 1'b1);
    clr = 1'b0;
    #1;
    check("mid_reset_async", q4, 1'b0);
    #3 clr = 1'b1;
    // The discarded bits must not reappear.
    tick();
    check("after_reset_shift1", q4, 1'b0);
    tick();
    check("after_reset_shift2", q4, 1'b0);
    // Load 0101: Q = 1 | 0,1,0,0.
    load4 = 1'b1; d4 = 4'b0101;
    tick();
    check("load_0101", q4, 1'b1);
    load4 = 1'b0;
    exp_seq4 = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("shift_0101", q4, exp_seq4[i]);
    end

    // Reload mid-shift: load 1111, shift once, reload 0110: Q = 0,1,1,0, then 0.
    load4 = 1'b1; d4 = 4'b1111;
    tick();
    check("load_1111", q4, 1'b1);
    load4 = 1'b0;
    tick();
    check("shift_1111", q4, 1'b1);
    load4 = 1'b1; d4 = 4'b0110;
    tick();
    check("reload_0110", q4, 1'b0);
    load4 = 1'b0;
    exp_seq4 = 4'b0011;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("shift_0110", q4, exp_seq4[i]);
    end

    // Reset beats load on the same edge.
    clr = 1'b0; load4 = 1'b1; d4 = 4'b1111;
    tick();
    check("reset_vs_load", q4, 1'b0);
    clr = 1'b1;
    tick();
    check("load_after_release", q4, 1'b1);

    // Continuous load: Q tracks D[0] one edge later.
    d4 = 4'b1110;
    tick();
    check("cont_load_0", q4, 1'b0);
    d4 = 4'b0001;
    tick();
    check("cont_load_1", q4, 1'b1);
    load4 = 1'b0;

    // WIDTH=8: load 1000_0001, shift 9 edges: Q = 1 | 0,0,0,0,0,0,1,0,0.
    load8 = 1'b1; d8 = 8'b1000_0001;
    tick();
    check("w8_load", q8, 1'b1);
    load8 = 1'b0; d8 = 8'hff;
    exp_seq8 = 9'b0_0100_0000;
    for (int i = 0; i < 9; i++) begin
      tick();
      check("w8_shift", q8, exp_seq8[i]);
    end

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
